// File: rtl/ux607_pwm8_icb_arb.sv
// Two-requester ICB arbiter in front of the PWM8 slave: round-robin grant, one
// outstanding transaction, command and response paths forwarded combinationally.
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

module ux607_pwm8_icb_arb #(
    parameter int AW = `UX607_PA_SIZE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_icb_cmd_valid,
    output logic          m0_icb_cmd_ready,
    input  logic [AW-1:0] m0_icb_cmd_addr,
    input  logic          m0_icb_cmd_read,
    input  logic [31:0]   m0_icb_cmd_wdata,
    output logic          m0_icb_rsp_valid,
    input  logic          m0_icb_rsp_ready,
    output logic [31:0]   m0_icb_rsp_rdata,
    input  logic          m1_icb_cmd_valid,
    output logic          m1_icb_cmd_ready,
    input  logic [AW-1:0] m1_icb_cmd_addr,
    input  logic          m1_icb_cmd_read,
    input  logic [31:0]   m1_icb_cmd_wdata,
    output logic          m1_icb_rsp_valid,
    input  logic          m1_icb_rsp_ready,
    output logic [31:0]   m1_icb_rsp_rdata,
    output logic          s_icb_cmd_valid,
    input  logic          s_icb_cmd_ready,
    output logic [AW-1:0] s_icb_cmd_addr,
    output logic          s_icb_cmd_read,
    output logic [31:0]   s_icb_cmd_wdata,
    input  logic          s_icb_rsp_valid,
    output logic          s_icb_rsp_ready,
    input  logic [31:0]   s_icb_rsp_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RSP = 2'd2} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;

    logic [1:0]    cmd_valid_vec;
    logic [1:0]    cmd_read_vec;
    logic [1:0]    rsp_ready_vec;
    logic [AW-1:0] cmd_addr_arr  [2];
    logic [31:0]   cmd_wdata_arr [2];
    logic [1:0]    cmd_ready_vec;
    logic [1:0]    rsp_valid_vec;
    logic [31:0]   rsp_rdata_arr [2];
    logic          own_cmd_valid;

    assign cmd_valid_vec    = {m1_icb_cmd_valid, m0_icb_cmd_valid};
    assign cmd_read_vec     = {m1_icb_cmd_read, m0_icb_cmd_read};
    assign rsp_ready_vec    = {m1_icb_rsp_ready, m0_icb_rsp_ready};
    assign cmd_addr_arr[0]  = m0_icb_cmd_addr;
    assign cmd_addr_arr[1]  = m1_icb_cmd_addr;
    assign cmd_wdata_arr[0] = m0_icb_cmd_wdata;
    assign cmd_wdata_arr[1] = m1_icb_cmd_wdata;
    assign own_cmd_valid    = cmd_valid_vec[owner_reg];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;  // requester 0 wins the first tie
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_next       = last_reg;
        s_icb_cmd_valid = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_read  = 1'b0;
        s_icb_cmd_wdata = '0;
        s_icb_rsp_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|cmd_valid_vec) begin
                    state_next = CMD;
                    owner_next = (&cmd_valid_vec) ? ~last_reg : cmd_valid_vec[1];
                end
            end
            CMD: begin
                s_icb_cmd_valid = own_cmd_valid;
                if (own_cmd_valid) begin
                    s_icb_cmd_addr  = cmd_addr_arr[owner_reg];
                    s_icb_cmd_read  = cmd_read_vec[owner_reg];
                    s_icb_cmd_wdata = cmd_wdata_arr[owner_reg];
                end
                // A withdrawn request releases the grant without touching last
                if (!own_cmd_valid)
                    state_next = IDLE;
                else if (s_icb_cmd_ready)
                    state_next = RSP;
            end
            RSP: begin
                s_icb_rsp_ready = rsp_ready_vec[owner_reg];
                if (s_icb_rsp_valid && rsp_ready_vec[owner_reg]) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        localparam logic IDX = 1'(gi);
        assign cmd_ready_vec[gi] = (state_reg == CMD) && (owner_reg == IDX) && s_icb_cmd_ready;
        assign rsp_valid_vec[gi] = (state_reg == RSP) && (owner_reg == IDX) && s_icb_rsp_valid;
        assign rsp_rdata_arr[gi] = ((state_reg == RSP) && (owner_reg == IDX)) ? s_icb_rsp_rdata : 32'd0;
    end

    assign m0_icb_cmd_ready = cmd_ready_vec[0];
    assign m1_icb_cmd_ready = cmd_ready_vec[1];
    assign m0_icb_rsp_valid = rsp_valid_vec[0];
    assign m1_icb_rsp_valid = rsp_valid_vec[1];
    assign m0_icb_rsp_rdata = rsp_rdata_arr[0];
    assign m1_icb_rsp_rdata = rsp_rdata_arr[1];
    assign busy             = (state_reg != IDLE);
    assign owner            = owner_reg;

endmodule

// File: tb/tb_ux607_pwm8_icb_arb.sv
// Scoreboard bench for the PWM8 ICB arbiter: queued master commands, a simple
// slave responder, and expected slave/master traffic popped as it appears.
module tb_ux607_pwm8_icb_arb;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0] m0_icb_cmd_addr;
    logic [31:0]   m0_icb_cmd_wdata, m0_icb_rsp_rdata;
    logic          m0_icb_rsp_valid, m0_icb_rsp_ready;
    logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0] m1_icb_cmd_addr;
    logic [31:0]   m1_icb_cmd_wdata, m1_icb_rsp_rdata;
    logic          m1_icb_rsp_valid, m1_icb_rsp_ready;
    logic          s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [AW-1:0] s_icb_cmd_addr;
    logic [31:0]   s_icb_cmd_wdata, s_icb_rsp_rdata;
    logic          s_icb_rsp_valid, s_icb_rsp_ready;
    logic          busy, owner;

    ux607_pwm8_icb_arb #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_rsp_valid(m0_icb_rsp_valid),
        .m0_icb_rsp_ready(m0_icb_rsp_ready), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_rsp_valid(m1_icb_rsp_valid),
        .m1_icb_rsp_ready(m1_icb_rsp_ready), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_rsp_valid(s_icb_rsp_valid),
        .s_icb_rsp_ready(s_icb_rsp_ready), .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .busy(busy), .owner(owner)
    );

    typedef struct packed {
        logic        m;
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } txn_t;

    txn_t        mq0[$], mq1[$], exp_slave[$];
    logic [31:0] exp_rsp0[$], exp_rsp1[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int cmd_hold = 0, rsp_hold0 = 0, rsp_hold1 = 0, rsp_delay_cfg = 0, slave_delay = 0;
    int cmd_stalls = 0, rsp_stalls = 0, cmd_hs_cnt = 0, rsp_hs_cnt = 0;
    int cmd_hs_cyc = 0, rsp_hs_cyc = 0;
    bit slave_pending = 0;
    logic [31:0] slave_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return a * 32'h11 + 32'h1D;   // 0x8 -> 0xA5
    endfunction

    // Drive master/slave inputs on the falling edge, observe 1ns later
    initial begin
        txn_t e;
        m0_icb_cmd_valid = 0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 0; m0_icb_cmd_wdata = '0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 0; m1_icb_cmd_wdata = '0;
        m0_icb_rsp_ready = 0; m1_icb_rsp_ready = 0;
        s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            m0_icb_cmd_valid = (mq0.size() > 0);
            m0_icb_cmd_addr  = (mq0.size() > 0) ? mq0[0].addr  : '0;
            m0_icb_cmd_read  = (mq0.size() > 0) ? mq0[0].rd    : 1'b0;
            m0_icb_cmd_wdata = (mq0.size() > 0) ? mq0[0].wdata : '0;
            m1_icb_cmd_valid = (mq1.size() > 0);
            m1_icb_cmd_addr  = (mq1.size() > 0) ? mq1[0].addr  : '0;
            m1_icb_cmd_read  = (mq1.size() > 0) ? mq1[0].rd    : 1'b0;
            m1_icb_cmd_wdata = (mq1.size() > 0) ? mq1[0].wdata : '0;
            m0_icb_rsp_ready = (rsp_hold0 == 0);
            m1_icb_rsp_ready = (rsp_hold1 == 0);
            s_icb_cmd_ready  = (cmd_hold == 0);
            s_icb_rsp_valid  = slave_pending && (slave_delay == 0);
            s_icb_rsp_rdata  = s_icb_rsp_valid ? slave_rdata : '0;
            #1;
            if (rst_n) begin
                if (slave_pending && !s_icb_rsp_valid && slave_delay > 0) slave_delay--;
                if (s_icb_rsp_valid && s_icb_rsp_ready) slave_pending = 0;
                if (m0_icb_rsp_valid && !m0_icb_rsp_ready) begin
                    rsp_stalls++;
                    if (rsp_hold0 > 0) rsp_hold0--;
                end
                if (m1_icb_rsp_valid && !m1_icb_rsp_ready) begin
                    rsp_stalls++;
                    if (rsp_hold1 > 0) rsp_hold1--;
                end
                if (m0_icb_rsp_valid && m0_icb_rsp_ready) begin
                    rsp_hs_cnt++; rsp_hs_cyc = cyc;
                    if (exp_rsp0.size() == 0) chk("unexp_rsp0", 1, 0);
                    else chk("rsp0_rdata", m0_icb_rsp_rdata, exp_rsp0.pop_front());
                    chk("rsp0_other_idle", {m1_icb_rsp_valid, m1_icb_rsp_rdata}, 0);
                    $display("txn rsp m0 rdata=%08h cyc=%0d", m0_icb_rsp_rdata, cyc);
                end
                if (m1_icb_rsp_valid && m1_icb_rsp_ready) begin
                    rsp_hs_cnt++; rsp_hs_cyc = cyc;
                    if (exp_rsp1.size() == 0) chk("unexp_rsp1", 1, 0);
                    else chk("rsp1_rdata", m1_icb_rsp_rdata, exp_rsp1.pop_front());
                    chk("rsp1_other_idle", {m0_icb_rsp_valid, m0_icb_rsp_rdata}, 0);
                    $display("txn rsp m1 rdata=%08h cyc=%0d", m1_icb_rsp_rdata, cyc);
                end
                if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
                    cmd_stalls++;
                    if (cmd_hold > 0) cmd_hold--;
                end
                if (s_icb_cmd_valid && s_icb_cmd_ready) begin
                    cmd_hs_cnt++; cmd_hs_cyc = cyc;
                    if (exp_slave.size() == 0) chk("unexp_cmd", 1, 0);
                    else begin
                        e = exp_slave.pop_front();
                        chk("cmd_owner", owner, e.m);
                        chk("cmd_addr", s_icb_cmd_addr, e.addr);
                        chk("cmd_read", s_icb_cmd_read, e.rd);
                        chk("cmd_wdata", s_icb_cmd_wdata, e.wdata);
                    end
                    $display("txn cmd owner=%0d addr=%08h rd=%0d wdata=%08h cyc=%0d",
                             owner, s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, cyc);
                    slave_pending = 1;
                    slave_rdata   = slv_data(s_icb_cmd_addr);
                    slave_delay   = rsp_delay_cfg;
                end
                if (m0_icb_cmd_valid && m0_icb_cmd_ready && mq0.size() > 0) void'(mq0.pop_front());
                if (m1_icb_cmd_valid && m1_icb_cmd_ready && mq1.size() > 0) void'(mq1.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic issue(input bit m, input logic [31:0] a, input bit rd, input logic [31:0] wd,
                         input bit want_rsp);
        txn_t t;
        t.m = m; t.addr = a; t.rd = rd; t.wdata = wd;
        if (m) mq1.push_back(t); else mq0.push_back(t);
        exp_slave.push_back(t);
        if (want_rsp) begin
            if (m) exp_rsp1.push_back(slv_data(a)); else exp_rsp0.push_back(slv_data(a));
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((mq0.size() > 0 || mq1.size() > 0 || exp_slave.size() > 0 ||
                exp_rsp0.size() > 0 || exp_rsp1.size() > 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < budget), 1);
    endtask

    initial begin
        int start, hs0, rs0, n;
        repeat (3) tick();
        chk("rst_busy_owner", {busy, owner}, 0);
        chk("rst_handshakes", {m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid,
                               m1_icb_rsp_valid, s_icb_cmd_valid, s_icb_rsp_ready}, 0);
        rst_n = 1;
        tick();
        chk("post_rst_outputs", {busy, owner, s_icb_cmd_valid, s_icb_rsp_ready}, 0);

        // Simultaneous writes right after reset: m0 first, then m1
        issue(0, 32'h10, 0, 32'h11, 1);
        issue(1, 32'h14, 0, 32'h22, 1);
        wait_done("tie", 30);

        // Both held valid for six transactions: strict alternation, 3 cycles each
        start = cyc;
        for (int i = 0; i < 6; i++) issue(i[0], 32'h100 + 32'(i * 4), 0, 32'hC0 + 32'(i), 1);
        wait_done("fair", 60);
        chk("fair_cycles", rsp_hs_cyc - start, 18);

        // Single read with minimum latency
        start = cyc;
        issue(0, 32'h8, 1, 32'h0, 1);
        wait_done("read", 20);
        chk("read_cmd_lat", cmd_hs_cyc - start, 2);
        chk("read_rsp_lat", rsp_hs_cyc - start, 3);
        chk("read_busy_fall", cyc - start, 4);

        // Backpressure on slave command and master response
        cmd_stalls = 0; rsp_stalls = 0; hs0 = cmd_hs_cnt; rs0 = rsp_hs_cnt;
        cmd_hold = 4; rsp_hold0 = 3;
        issue(0, 32'h20, 1, 32'h0, 1);
        wait_done("bp", 40);
        chk("bp_cmd_stalls", cmd_stalls, 4);
        chk("bp_rsp_stalls", rsp_stalls, 3);
        chk("bp_cmd_count", cmd_hs_cnt - hs0, 1);
        chk("bp_rsp_count", rsp_hs_cnt - rs0, 1);

        // m1 granted then withdraws in CMD (last is 0 here)
        cmd_hold = 1000; hs0 = cmd_hs_cnt;
        begin
            txn_t t;
            t.m = 1; t.addr = 32'h60; t.rd = 0; t.wdata = 32'h66;
            mq1.push_back(t);
        end
        n = 0;
        while (!(busy && owner) && n < 10) begin tick(); n++; end
        chk("wd_grant", {busy, owner}, 2'b11);
        mq1.delete();
        tick();
        chk("wd_s_valid", s_icb_cmd_valid, 0);
        tick();
        chk("wd_idle", busy, 0);
        chk("wd_no_hs", cmd_hs_cnt - hs0, 0);
        cmd_hold = 0;
        // last still 0, so m1 wins the next tie
        issue(1, 32'h30, 0, 32'h33, 1);
        issue(0, 32'h34, 0, 32'h44, 1);
        wait_done("wd_tie", 30);

        // Reset while in RSP abandons the transaction
        rsp_delay_cfg = 4; hs0 = cmd_hs_cnt;
        issue(0, 32'h40, 1, 32'h0, 0);
        n = 0;
        while (cmd_hs_cnt == hs0 && n < 10) begin tick(); n++; end
        chk("rr_cmd_seen", cmd_hs_cnt - hs0, 1);
        tick();
        chk("rr_in_rsp", busy, 1);
        rst_n = 0;
        tick();
        chk("rr_after_rst", {busy, owner, m0_icb_rsp_valid, m1_icb_rsp_valid}, 0);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_no_rsp", {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready, busy}, 0);
        end
        chk("rr_late_slave_rsp", s_icb_rsp_valid, 1);
        slave_pending = 0; rsp_delay_cfg = 0;
        tick();

        // After reset, requester 0 wins the tie again
        issue(0, 32'h50, 0, 32'h55, 1);
        issue(1, 32'h54, 0, 32'h77, 1);
        wait_done("post_rst_tie", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
